// File: rtl/wb_master_initiator_pkg.sv
// wb_master_pkg: shared FSM encoding, timeout read data and timeout counter width helper
package wb_master_pkg;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  localparam logic [1023:0] TIMEOUT_RDATA = '1;
  function automatic int cnt_w(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction
endpackage

// File: rtl/wb_master_initiator_if.sv
// wb_master_if: request/response channels plus Wishbone classic bus; master = initiator block, slave = its environment
interface wb_master_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_adr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W/8-1:0] req_sel;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic wbm_cyc, wbm_stb, wbm_we, wbm_ack;
  logic [DATA_W/8-1:0] wbm_sel;
  logic [ADDR_W-1:0] wbm_adr;
  logic [DATA_W-1:0] wbm_wdata, wbm_rdata;
  modport master(
    input req_valid, req_we, req_adr, req_wdata, req_sel, rsp_ready, wbm_ack, wbm_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, wbm_cyc, wbm_stb, wbm_we, wbm_sel, wbm_adr, wbm_wdata
  );
  modport slave(
    output req_valid, req_we, req_adr, req_wdata, req_sel, rsp_ready, wbm_ack, wbm_rdata,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, wbm_cyc, wbm_stb, wbm_we, wbm_sel, wbm_adr, wbm_wdata
  );
endinterface

// File: rtl/wb_master_initiator_timeout_cnt.sv
// wbm_timeout_cnt: saturating bus-cycle counter; ports wb_clk, wb_rst_n, i_clr, i_en, o_expired (high on the last allowed no-ack cycle)
module wbm_timeout_cnt
  import wb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic wb_clk,
  input  logic wb_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = cnt_w(TIMEOUT_CYCLES);
  logic [W-1:0] r_cnt;
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en && r_cnt != W'(TIMEOUT_CYCLES)) r_cnt <= r_cnt + 1'b1;
  end
  assign o_expired = (TIMEOUT_CYCLES != 0) && i_en && (r_cnt == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/wb_master_initiator.sv
// wb_master_initiator: valid/ready request -> single Wishbone classic cycle -> valid/ready response; ports wb_clk, wb_rst_n, bus (wb_master_if.master), busy
module wb_master_initiator
  import wb_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         wb_clk,
  input  logic         wb_rst_n,
  wb_master_if.master  bus,
  output logic         busy
);
  state_t r_state;
  logic r_cyc, r_we, r_rsp_valid, r_rsp_err;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [DATA_W/8-1:0] r_sel;
  logic w_accept, w_ack, w_expired;
  assign w_accept = bus.req_valid & bus.req_ready;
  assign w_ack = r_cyc & bus.wbm_ack;
  assign bus.req_ready = wb_rst_n & (r_state == IDLE);
  assign bus.wbm_cyc = r_cyc;
  assign bus.wbm_stb = r_cyc;
  assign bus.wbm_we = r_cyc & r_we;
  assign bus.wbm_adr = r_cyc ? r_adr : '0;
  assign bus.wbm_sel = r_cyc ? r_sel : '0;
  assign bus.wbm_wdata = r_cyc ? r_wdata : '0;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err = r_rsp_err;
  assign busy = r_state != IDLE;
  wbm_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .wb_clk    (wb_clk),
    .wb_rst_n  (wb_rst_n),
    .i_clr     (w_accept),
    .i_en      (r_cyc & ~bus.wbm_ack),
    .o_expired (w_expired)
  );
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= IDLE;
      r_cyc <= 1'b0;
      r_we <= 1'b0;
      r_adr <= '0;
      r_wdata <= '0;
      r_sel <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_state <= BUS;
        r_cyc <= 1'b1;
        r_we <= bus.req_we;
        r_adr <= bus.req_adr;
        r_wdata <= bus.req_wdata;
        r_sel <= bus.req_sel;
      end
      if (w_ack || w_expired) begin
        r_state <= RESP;
        r_cyc <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_err <= ~w_ack;
        r_rdata <= w_ack ? (r_we ? '0 : bus.wbm_rdata) : TIMEOUT_RDATA[DATA_W-1:0];
      end
      if (r_rsp_valid && bus.rsp_ready) begin
        r_state <= IDLE;
        r_rsp_valid <= 1'b0;
        r_rsp_err <= 1'b0;
        r_rdata <= '0;
      end
    end
  end
endmodule

// File: tb/tb_wb_master_initiator.sv
// tb_wb_master_initiator: scoreboard bench for the Wishbone initiator with a cycle-counting slave model
module tb_wb_master_initiator;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy;
  always #5 clk = ~clk;
  wb_master_if #(.ADDR_W(32), .DATA_W(32)) bus();
  wb_master_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk   (clk),
    .wb_rst_n (rst_n),
    .bus      (bus.master),
    .busy     (busy)
  );
  int n_chk = 0;
  int n_pass = 0;
  logic [32:0] exp_q[$];
  logic t_we;
  logic [31:0] t_adr, t_wdata, t_rdata;
  logic [3:0] t_sel;
  int t_ack;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask
  function automatic logic [32:0] model(input logic we, input int ack_at, input logic [31:0] rd);
    return (ack_at == 0 || ack_at > TO) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, we ? 32'h0 : rd};
  endfunction
  function automatic int bus_len(input int ack_at);
    return (ack_at == 0 || ack_at > TO) ? TO : ack_at;
  endfunction
  task automatic drive_req(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                           input logic [3:0] sel, input int ack_at, input logic [31:0] rd);
    t_we = we;
    t_adr = adr;
    t_wdata = wdata;
    t_sel = sel;
    t_ack = ack_at;
    t_rdata = rd;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_adr = adr;
    bus.req_wdata = wdata;
    bus.req_sel = sel;
  endtask
  task automatic handshake();
    int k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready", bus.req_ready, 1);
    exp_q.push_back(model(t_we, t_ack, t_rdata));
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic serve();
    int n = 0;
    while (bus.wbm_cyc && n < 40) begin
      n++;
      chk("bus", {bus.wbm_stb, bus.wbm_we, bus.wbm_sel, bus.wbm_adr, bus.wbm_wdata},
          {1'b1, t_we, t_sel, t_adr, t_wdata});
      bus.wbm_ack = (n == t_ack);
      bus.wbm_rdata = (n == t_ack) ? t_rdata : $urandom;
      @(negedge clk);
    end
    bus.wbm_ack = 1'b0;
    chk("bus_len", n, bus_len(t_ack));
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("idle_bus", {bus.wbm_cyc, bus.wbm_stb, bus.wbm_we, bus.wbm_sel, bus.wbm_adr, bus.wbm_wdata}, 0);
  endtask
  task automatic take();
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      chk("q_underflow", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk("rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {1'b1, e});
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("after_rsp", {bus.rsp_valid, busy, bus.req_ready}, 3'b001);
  endtask
  task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                     input logic [3:0] sel, input int ack_at, input logic [31:0] rd);
    drive_req(we, adr, wdata, sel, ack_at, rd);
    handshake();
    serve();
    take();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_adr = '0;
    bus.req_wdata = '0;
    bus.req_sel = '0;
    bus.rsp_ready = 1'b0;
    bus.wbm_ack = 1'b0;
    bus.wbm_rdata = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.wbm_cyc, bus.wbm_stb,
                    bus.wbm_we, bus.wbm_sel, bus.wbm_adr, bus.wbm_wdata, busy}, 0);
    rst_n = 1'b1;
    #1 chk("rst_rdy", bus.req_ready, 1);
    @(negedge clk);
    txn(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 3, 32'h0);
    txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1, 32'hDEAD_BEEF);
    drive_req(1'b0, 32'h3000_0020, 32'h0, 4'h3, 0, 32'h0);
    handshake();
    serve();
    @(negedge clk);
    bus.wbm_ack = 1'b1;
    bus.wbm_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.wbm_ack = 1'b0;
    chk("stray_resp", {bus.wbm_cyc, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF});
    take();
    txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, TO, 32'h1);
    drive_req(1'b0, 32'h3000_0040, 32'h0, 4'hF, 2, 32'h0BAD_F00D);
    handshake();
    serve();
    drive_req(1'b1, 32'h3000_0044, 32'h5555_AAAA, 4'h5, 1, 32'h0);
    repeat (5) begin
      chk("bp", {bus.req_ready, bus.wbm_cyc, busy, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata},
          {1'b0, 1'b0, 1'b1, 1'b1, exp_q[0]});
      @(negedge clk);
    end
    take();
    handshake();
    chk("bp_start", bus.wbm_cyc, 1);
    serve();
    take();
    for (int i = 0; i < 6; i++)
      txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(1, 15)),
          int'($urandom_range(1, TO + 2)), $urandom);
    bus.wbm_ack = 1'b1;
    bus.wbm_rdata = 32'hCAFE_0000;
    repeat (2) @(negedge clk);
    bus.wbm_ack = 1'b0;
    chk("stray_idle", {bus.wbm_cyc, bus.rsp_valid, busy, bus.req_ready}, 4'b0001);
    drive_req(1'b1, 32'h3000_0050, 32'h1111_2222, 4'hC, 0, 32'h0);
    handshake();
    repeat (3) @(negedge clk);
    chk("pre_rst_cyc", bus.wbm_cyc, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {bus.wbm_cyc, bus.wbm_stb, bus.rsp_valid, bus.req_ready, busy}, 0);
    chk("q_pending", exp_q.size(), 1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_rel", {bus.req_ready, busy, bus.rsp_valid, bus.wbm_cyc}, 4'b1000);
    repeat (4) begin
      @(negedge clk);
      chk("no_rsp", {bus.rsp_valid, bus.wbm_cyc}, 0);
    end
    txn(1'b0, 32'h3000_0060, 32'h0, 4'hF, 2, 32'h7777_0001);
    chk("q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
